// File: rtl/n_wb_sequencer.sv
// NPU result write-back sequencer: drains a vector of up to N_RES byte results
// into the register file, one write per cycle, on the NPU port of the register
// write-port selector, yielding to pending CPU write-back.
module n_wb_sequencer #(
    parameter int unsigned N_RES = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               res_valid_i,
    output logic               res_ready_o,
    input  logic [8*N_RES-1:0] res_data_i,
    input  logic [2:0]         res_count_i,
    input  logic [4:0]         base_addr_i,
    input  logic               cpu_w_pending_i,
    output logic               npu_alu_sel_o,
    output logic               en_w_reg_npu_o,
    output logic [4:0]         w_reg_addr_npu_o,
    output logic [7:0]         w_reg_data_npu_o,
    output logic               done_o
);

    localparam int unsigned DATA_W      = 8 * N_RES;
    localparam logic        SEL_NPU_ALU = 1'b1;
    localparam logic        SEL_NON_NPU = 1'b0;
    localparam logic [2:0]  MAX_COUNT   = 3'(N_RES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          idx_q;
    logic [2:0]          count_q;
    logic [4:0]          base_q;
    logic [DATA_W-1:0]   buf_q;

    logic                accept;
    logic                issue;
    logic                last;
    logic [2:0]          eff_count;

    // Clamp the requested count to the vector capacity
    assign eff_count = (res_count_i > MAX_COUNT) ? MAX_COUNT : res_count_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; writes are gated by CPU priority and reset
    always_comb begin
        state_d        = state_q;
        res_ready_o    = 1'b0;
        accept         = 1'b0;
        issue          = 1'b0;
        last           = 1'b0;
        en_w_reg_npu_o = 1'b0;
        npu_alu_sel_o  = SEL_NON_NPU;
        done_o         = 1'b0;
        case (state_q)
            IDLE: begin
                res_ready_o = rst_n_i;
                accept      = res_valid_i && rst_n_i;
                if (accept) begin
                    state_d = (eff_count == 3'd0) ? FIN : WRITE;
                end
            end
            WRITE: begin
                issue          = !cpu_w_pending_i && rst_n_i;
                last           = (idx_q == (count_q - 3'd1));
                en_w_reg_npu_o = issue;
                npu_alu_sel_o  = issue ? SEL_NPU_ALU : SEL_NON_NPU;
                if (issue && last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Vector capture and write index; idx stops on the last entry so the
    // address/data outputs keep showing the final write afterwards
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            buf_q   <= '0;
            base_q  <= 5'd0;
            count_q <= 3'd0;
            idx_q   <= 3'd0;
        end else if (accept) begin
            buf_q   <= res_data_i;
            base_q  <= base_addr_i;
            count_q <= eff_count;
            idx_q   <= 3'd0;
        end else if (issue && !last) begin
            idx_q   <= idx_q + 3'd1;
        end
    end

    // Write address wraps modulo 32
    assign w_reg_addr_npu_o = base_q + {2'b00, idx_q};

    // Select the current result byte
    always_comb begin
        w_reg_data_npu_o = 8'd0;
        for (int unsigned k = 0; k < N_RES; k++) begin
            if (idx_q == 3'(k)) begin
                w_reg_data_npu_o = buf_q[8*k +: 8];
            end
        end
    end

endmodule
